// File: rtl/csi_rx_skew_calib.sv
// Purpose : per-lane IDELAY tap sweep for the 2-lane CSI-2 Rx; picks the centre of the longest passing tap window.
// Latency : 64 * (3 + SETTLE_CYCLES + OBSERVE_CYCLES) + 4 cycles from start to the done pulse.
// Backpres: none; start is ignored unless idle, byte_valid is only looked at while observing a tap.
module csi_rx_skew_calib #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int OBSERVE_CYCLES = 1024,
    parameter int MIN_VALID      = 256,
    parameter int DEFAULT_TAP    = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] byte_valid,
    output logic [4:0] skew_d0,
    output logic [4:0] skew_d1,
    output logic       load,
    output logic       busy,
    output logic       done,
    output logic [1:0] cal_error,
    output logic [5:0] win_len_d0,
    output logic [5:0] win_len_d1
);

    // Valid counter must hold OBSERVE_CYCLES itself; the shared timer must reach either phase length.
    localparam int CW = $clog2(OBSERVE_CYCLES + 1);
    localparam int TW = (SETTLE_CYCLES > OBSERVE_CYCLES) ? $clog2(SETTLE_CYCLES + 1)
                                                         : $clog2(OBSERVE_CYCLES + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] OBS_LAST    = TW'(OBSERVE_CYCLES - 1);
    localparam logic [CW-1:0] OBS_MAX     = CW'(OBSERVE_CYCLES);
    localparam logic [CW-1:0] MIN_CNT     = CW'(MIN_VALID);
    localparam logic [4:0]    DEF_TAP     = 5'(DEFAULT_TAP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET,
        S_LOAD,
        S_SETTLE,
        S_OBSERVE,
        S_EVAL,
        S_PICK,
        S_APPLY,
        S_DONE
    } state_t;

    state_t          state;
    logic            lane;
    logic [4:0]      tap;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   valid_cnt;

    // Run tracker: current passing run and best closed run for the lane being swept.
    logic [4:0]      cur_start;
    logic [5:0]      cur_len;
    logic [4:0]      best_start;
    logic [5:0]      best_len;

    logic            tap_pass;
    logic [5:0]      run_len;
    logic [4:0]      run_start;
    logic [5:0]      cand_len;
    logic [4:0]      cand_start;
    logic            run_closes;
    logic [4:0]      center;

    // Score the tap just observed and work out what the tracker would look like after it.
    always_comb begin
        tap_pass   = (valid_cnt >= MIN_CNT);
        run_len    = tap_pass ? (cur_len + 6'd1) : 6'd0;
        run_start  = (tap_pass && (cur_len == 6'd0)) ? tap : cur_start;
        // A failing tap closes the run that ended before it; the last tap also closes a run still in progress.
        cand_len   = tap_pass ? run_len   : cur_len;
        cand_start = tap_pass ? run_start : cur_start;
        run_closes = !tap_pass || (tap == 5'd31);
        // Lower-middle tap of the window: start + floor((len-1)/2); never leaves 0..31.
        center     = best_start + 5'((best_len - 6'd1) >> 1);
    end

    // Calibration sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lane       <= 1'b0;
            tap        <= 5'd0;
            timer      <= '0;
            valid_cnt  <= '0;
            cur_start  <= 5'd0;
            cur_len    <= 6'd0;
            best_start <= 5'd0;
            best_len   <= 6'd0;
            skew_d0    <= DEF_TAP;
            skew_d1    <= DEF_TAP;
            load       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cal_error  <= 2'b00;
            win_len_d0 <= 6'd0;
            win_len_d1 <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cal_error  <= 2'b00;
                        win_len_d0 <= 6'd0;
                        win_len_d1 <= 6'd0;
                        lane       <= 1'b0;
                        tap        <= 5'd0;
                        cur_start  <= 5'd0;
                        cur_len    <= 6'd0;
                        best_start <= 5'd0;
                        best_len   <= 6'd0;
                        busy       <= 1'b1;
                        state      <= S_SET;
                    end
                end

                S_SET: begin
                    if (lane) begin
                        skew_d1 <= tap;
                    end else begin
                        skew_d0 <= tap;
                    end
                    load  <= 1'b1;
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    load      <= 1'b0;
                    timer     <= '0;
                    valid_cnt <= '0;
                    state     <= (SETTLE_CYCLES == 0) ? S_OBSERVE : S_SETTLE;
                end

                S_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        state <= S_OBSERVE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_OBSERVE: begin
                    if (byte_valid[lane] && (valid_cnt != OBS_MAX)) begin
                        valid_cnt <= valid_cnt + CW'(1);
                    end
                    if (timer == OBS_LAST) begin
                        timer <= '0;
                        state <= S_EVAL;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_EVAL: begin
                    cur_len   <= run_len;
                    cur_start <= run_start;
                    // Strictly longer only, so the lowest-start window wins a tie.
                    if (run_closes && (cand_len > best_len)) begin
                        best_len   <= cand_len;
                        best_start <= cand_start;
                    end
                    if (tap == 5'd31) begin
                        state <= S_PICK;
                    end else begin
                        tap   <= tap + 5'd1;
                        state <= S_SET;
                    end
                end

                S_PICK: begin
                    if (best_len != 6'd0) begin
                        if (lane) begin
                            skew_d1    <= center;
                            win_len_d1 <= best_len;
                        end else begin
                            skew_d0    <= center;
                            win_len_d0 <= best_len;
                        end
                    end else begin
                        if (lane) begin
                            skew_d1 <= DEF_TAP;
                        end else begin
                            skew_d0 <= DEF_TAP;
                        end
                        cal_error[lane] <= 1'b1;
                    end
                    if (!lane) begin
                        // Lane 0 result stays applied while lane 1 is swept.
                        lane       <= 1'b1;
                        tap        <= 5'd0;
                        cur_start  <= 5'd0;
                        cur_len    <= 6'd0;
                        best_start <= 5'd0;
                        best_len   <= 6'd0;
                        state      <= S_SET;
                    end else begin
                        load  <= 1'b1;
                        state <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    load  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    load  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi_rx_skew_calib.sv
// Bench for csi_rx_skew_calib: table of per-lane pass masks with expected results, random masks
// checked against a window-search model, plus reset and stray-start sequences.
module tb_csi_rx_skew_calib;

    localparam int S  = 4;
    localparam int O  = 8;
    localparam int MV = 4;
    localparam int DT = 7;
    localparam int LAT = 64 * (3 + S + O) + 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] byte_valid = 2'b00;
    logic [4:0] skew_d0, skew_d1;
    logic       load, busy, done;
    logic [1:0] cal_error;
    logic [5:0] win_len_d0, win_len_d1;

    csi_rx_skew_calib #(
        .SETTLE_CYCLES (S),
        .OBSERVE_CYCLES(O),
        .MIN_VALID     (MV),
        .DEFAULT_TAP   (DT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .byte_valid(byte_valid),
        .skew_d0   (skew_d0),
        .skew_d1   (skew_d1),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .cal_error (cal_error),
        .win_len_d0(win_len_d0),
        .win_len_d1(win_len_d1)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Valid cycles delivered inside the observe window, per lane and tap.
    int kt[2][32];

    int cyc = 0;
    int n_load = 0;
    int n_done = 0;
    int done_cyc = -1;
    int start_cyc = 0;
    int pos = 1000;
    int mon_lane = 0;
    int mon_tap = 0;
    logic prev_load = 1'b0;
    logic prev_done = 1'b0;
    logic [4:0] ls0 = 5'd0, ls1 = 5'd0;

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        bit          exact;
        int          s0, s1, w0, w1, er;
        int          mid;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Link model: tracks load pulses, checks their shape, and drives byte_valid from the per-tap table.
    always @(negedge clock) begin
        logic [1:0] bv;
        if (reset_n && prev_load) begin
            chk("load_width", int'(load), 0);
            chk("skew_stable_d0", int'(skew_d0), int'(ls0));
            chk("skew_stable_d1", int'(skew_d1), int'(ls1));
        end
        if (reset_n && prev_done) chk("done_width", int'(done), 0);
        prev_load = load;
        prev_done = done;
        ls0 = skew_d0;
        ls1 = skew_d1;
        if (load) begin
            pos = 0;
            n_load++;
            if (n_load <= 64) begin
                mon_lane = (n_load - 1) / 32;
                mon_tap  = (n_load - 1) % 32;
                chk("sweep_tap", mon_lane ? int'(skew_d1) : int'(skew_d0), mon_tap);
            end
        end else begin
            pos++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        bv = 2'($urandom);
        if (n_load >= 1 && n_load <= 64 && pos >= S + 1 && pos <= S + O)
            bv[mon_lane] = ((pos - S - 1) < kt[mon_lane][mon_tap]);
        byte_valid = bv;
    end

    function automatic int pick_k(input bit p, input bit exact);
        if (exact) return p ? MV : MV - 1;
        return p ? int'($urandom_range(O, MV)) : int'($urandom_range(MV - 1, 0));
    endfunction

    task automatic load_k(input logic [31:0] m0, input logic [31:0] m1, input bit exact);
        for (int t = 0; t < 32; t++) begin
            kt[0][t] = pick_k(m0[t], exact);
            kt[1][t] = pick_k(m1[t], exact);
        end
    endtask

    // Longest run of passing taps; a later run must be strictly longer to displace an earlier one.
    function automatic void model(input logic [31:0] m, output int sk, output int wl, output int er);
        int bl = 0, bs = 0, cl = 0, cs = 0;
        for (int t = 0; t < 32; t++) begin
            if (m[t]) begin
                if (cl == 0) cs = t;
                cl++;
                if (cl > bl) begin
                    bl = cl;
                    bs = cs;
                end
            end else begin
                cl = 0;
            end
        end
        wl = bl;
        er = (bl == 0);
        sk = (bl == 0) ? DT : bs + (bl - 1) / 2;
    endfunction

    // One full calibration; mid is a cycle offset from start at which a stray start is pulsed.
    task automatic run_cal(input string tag, input int mid);
        n_load = 0;
        n_done = 0;
        done_cyc = -1;
        @(negedge clock);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            @(negedge clock);
            start = (cyc == start_cyc + mid);
        end
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk({tag, "_done_seen"}, n_done, 1);
        chk({tag, "_latency"}, done_cyc - start_cyc, LAT);
        chk({tag, "_loads"}, n_load, 65);
        chk({tag, "_idle_after"}, int'(busy), 0);
    endtask

    task automatic check_res(input string tag, input int s0, input int s1,
                             input int w0, input int w1, input int er);
        chk({tag, "_skew_d0"}, int'(skew_d0), s0);
        chk({tag, "_skew_d1"}, int'(skew_d1), s1);
        chk({tag, "_win_d0"}, int'(win_len_d0), w0);
        chk({tag, "_win_d1"}, int'(win_len_d1), w1);
        chk({tag, "_cal_error"}, int'(cal_error), er);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_skew_d0"}, int'(skew_d0), DT);
        chk({tag, "_skew_d1"}, int'(skew_d1), DT);
        chk({tag, "_load"}, int'(load), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cal_error"}, int'(cal_error), 0);
        chk({tag, "_win_d0"}, int'(win_len_d0), 0);
        chk({tag, "_win_d1"}, int'(win_len_d1), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, w0, w1, e0, e1, lc;
        logic [31:0] m0, m1;

        // lane0 10..20; lane1 0..3 and 25..31 (run closed at tap 31); stray start mid-sweep
        vt[0] = '{32'h001F_FC00, 32'hFE00_000F, 1'b0, 15, 28, 11, 7, 0, 300};
        // tie 2..5 vs 20..23 picks the lower; full-scale window; start in the DONE cycle
        vt[1] = '{32'h00F0_003C, 32'hFFFF_FFFF, 1'b0, 3, 15, 4, 32, 0, LAT};
        // lane1 never passes
        vt[2] = '{32'h001F_FC00, 32'h0000_0000, 1'b0, 15, DT, 11, 0, 2, -1};
        // lane0 never passes, lane1 a single tap at 31
        vt[3] = '{32'h0000_0000, 32'h8000_0000, 1'b0, DT, 31, 0, 1, 1, -1};
        // threshold: pass taps get exactly MIN_VALID, fail taps exactly MIN_VALID-1
        vt[4] = '{32'h0000_01E0, 32'h0000_0000, 1'b1, 6, DT, 4, 0, 2, -1};

        #1 reset_n = 1'b0;
        #2 check_reset_vals("reset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_vals("after_release");

        for (int i = 0; i < 5; i++) begin
            load_k(vt[i].m0, vt[i].m1, vt[i].exact);
            run_cal($sformatf("vec%0d", i), vt[i].mid);
            check_res($sformatf("vec%0d", i), vt[i].s0, vt[i].s1, vt[i].w0, vt[i].w1, vt[i].er);
        end

        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0:       begin m0 = $urandom;             m1 = $urandom;             end
                1:       begin m0 = $urandom | $urandom;  m1 = $urandom | $urandom;  end
                default: begin m0 = $urandom & $urandom;  m1 = $urandom & $urandom;  end
            endcase
            load_k(m0, m1, 1'b0);
            model(m0, s0, w0, e0);
            model(m1, s1, w1, e1);
            run_cal($sformatf("rnd%0d", r), -1);
            check_res($sformatf("rnd%0d", r), s0, s1, w0, w1, e0 + 2 * e1);
        end

        // Reset during the lane 1 sweep, then a clean calibration afterwards.
        load_k(vt[0].m0, vt[0].m1, 1'b0);
        n_load = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 3000 && n_load < 40; i++) @(negedge clock);
        chk("rst_reached_lane1", int'(n_load >= 40), 1);
        #3 reset_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        lc = n_load;
        repeat (6) @(negedge clock);
        chk("rst_no_load", n_load, lc);
        chk("rst_busy_held", int'(busy), 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("rst_no_load_after", n_load, lc);
        chk("rst_no_done_after", int'(done), 0);
        run_cal("post_reset", -1);
        check_res("post_reset", 15, 28, 11, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
